// File: rtl/sa_wave_scheduler_pkg.sv
// sa_wave_scheduler_pkg: shared constants, widths and FSM state type for the wave scheduler
package sa_wave_scheduler_pkg;
  localparam int SA_N = 10;
  localparam int MAX_M = 32;
  localparam int RD_LAT = 1;
  localparam int AW = $clog2(MAX_M);
  localparam int WAW = $clog2(SA_N);
  localparam int MW = $clog2(MAX_M + 1);
  function automatic int t_width(input int n, input int max_m, input int rd_lat);
    return $clog2(rd_lat + max_m + 2 * n - 1);
  endfunction
  localparam int TW = t_width(SA_N, MAX_M, RD_LAT);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
endpackage

// File: rtl/sa_wave_scheduler_if.sv
// sa_wave_scheduler_if: job control plus buffer/array strobes of the wave scheduler
interface sa_wave_scheduler_if;
  import sa_wave_scheduler_pkg::*;
  logic start;
  logic abort;
  logic [MW-1:0] cfg_m;
  logic busy;
  logic done;
  logic err;
  logic wbuf_rd_en;
  logic [WAW-1:0] wbuf_rd_addr;
  logic w_ld_en;
  logic [WAW-1:0] w_ld_row;
  logic abuf_rd_en;
  logic [AW-1:0] abuf_rd_addr;
  logic [SA_N-1:0] inj_en;
  logic [SA_N-1:0] cap_en;
  logic [AW-1:0] cap_idx;
  modport master(
    output start, abort, cfg_m,
    input busy, done, err, wbuf_rd_en, wbuf_rd_addr, w_ld_en, w_ld_row,
    input abuf_rd_en, abuf_rd_addr, inj_en, cap_en, cap_idx
  );
  modport slave(
    input start, abort, cfg_m,
    output busy, done, err, wbuf_rd_en, wbuf_rd_addr, w_ld_en, w_ld_row,
    output abuf_rd_en, abuf_rd_addr, inj_en, cap_en, cap_idx
  );
endinterface

// File: rtl/sa_wave_scheduler_diag_mask.sv
// sa_wave_scheduler_diag_mask: bit b set when 0 <= t-offset-b < m (diagonal wavefront window)
module sa_wave_scheduler_diag_mask #(
  parameter int N = 10,
  parameter int TW = 6,
  parameter int MW = 6
) (
  input  logic [TW-1:0] t,
  input  logic [TW-1:0] offset,
  input  logic [MW-1:0] m,
  output logic [N-1:0]  mask
);
  always_comb begin
    mask = '0;
    for (int b = 0; b < N; b++)
      mask[b] = (int'(t) - int'(offset) - b >= 0) && (int'(t) - int'(offset) - b < int'(m));
  end
endmodule

// File: rtl/sa_wave_scheduler.sv
// sa_wave_scheduler: job FSM sequencing weight load, skewed activation stream and psum capture
module sa_wave_scheduler
  import sa_wave_scheduler_pkg::*;
(
  input logic clk,
  input logic rst_n,
  sa_wave_scheduler_if.slave bus
);
  localparam logic [TW-1:0] ONE = TW'(1);
  localparam logic [TW-1:0] T_OFF = TW'(RD_LAT + 2 * SA_N - 2);
  localparam logic [TW-1:0] INJ_OFF = TW'(RD_LAT);
  localparam logic [TW-1:0] CAP_OFF = TW'(RD_LAT + SA_N);
  localparam logic [TW-1:0] LAST_ROW = TW'(SA_N - 1);
  state_t state, nxt_state;
  logic [TW-1:0] t, nxt_t, t_last;
  logic [MW-1:0] m, nxt_m;
  logic cfg_ok, kill, strm;
  logic [SA_N-1:0] inj_m, cap_m;
  logic [RD_LAT-1:0] ld_en;
  logic [WAW-1:0] ld_row [RD_LAT];
  assign cfg_ok = bus.cfg_m != '0 && bus.cfg_m <= MW'(MAX_M);
  assign t_last = TW'(m) + T_OFF;
  assign kill = bus.abort && (state == LOAD_W || state == STREAM || state == DRAIN);
  assign strm = nxt_state == STREAM || nxt_state == DRAIN;
  assign bus.w_ld_en = ld_en[RD_LAT-1];
  assign bus.w_ld_row = ld_row[RD_LAT-1];
  // LOAD_W reuses t as the row counter; STREAM/DRAIN count t from 0
  always_comb begin
    nxt_state = state;
    nxt_t = t;
    nxt_m = m;
    case (state)
      IDLE: if (bus.start && cfg_ok) begin
        nxt_state = LOAD_W;
        nxt_t = '0;
        nxt_m = bus.cfg_m;
      end
      LOAD_W: begin
        nxt_state = t == LAST_ROW ? STREAM : LOAD_W;
        nxt_t = t == LAST_ROW ? '0 : t + ONE;
      end
      STREAM, DRAIN: begin
        nxt_state = t == t_last ? DONE : (t + ONE >= TW'(m) ? DRAIN : STREAM);
        nxt_t = t + ONE;
      end
      default: nxt_state = IDLE;
    endcase
    if (kill) begin
      nxt_state = IDLE;
      nxt_t = '0;
    end
  end
  sa_wave_scheduler_diag_mask #(.N(SA_N), .TW(TW), .MW(MW)) u_inj (
    .t(nxt_t), .offset(INJ_OFF), .m(nxt_m), .mask(inj_m)
  );
  sa_wave_scheduler_diag_mask #(.N(SA_N), .TW(TW), .MW(MW)) u_cap (
    .t(nxt_t), .offset(CAP_OFF), .m(nxt_m), .mask(cap_m)
  );
  // outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      t <= '0;
      m <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.wbuf_rd_en <= 1'b0;
      bus.wbuf_rd_addr <= '0;
      bus.abuf_rd_en <= 1'b0;
      bus.abuf_rd_addr <= '0;
      bus.inj_en <= '0;
      bus.cap_en <= '0;
      bus.cap_idx <= '0;
      ld_en <= '0;
      for (int i = 0; i < RD_LAT; i++) ld_row[i] <= '0;
    end else begin
      state <= nxt_state;
      t <= nxt_t;
      m <= nxt_m;
      bus.busy <= nxt_state != IDLE;
      bus.done <= nxt_state == DONE;
      bus.err <= state == IDLE && bus.start && !cfg_ok;
      bus.wbuf_rd_en <= nxt_state == LOAD_W;
      bus.wbuf_rd_addr <= nxt_state == LOAD_W ? WAW'(nxt_t) : '0;
      bus.abuf_rd_en <= nxt_state == STREAM;
      bus.abuf_rd_addr <= nxt_state == STREAM ? AW'(nxt_t) : '0;
      bus.inj_en <= strm ? inj_m : '0;
      bus.cap_en <= strm ? cap_m : '0;
      bus.cap_idx <= strm && cap_m[0] ? AW'(nxt_t - CAP_OFF) : '0;
      ld_en[0] <= bus.wbuf_rd_en && !kill;
      ld_row[0] <= kill ? '0 : bus.wbuf_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        ld_en[i] <= ld_en[i-1] && !kill;
        ld_row[i] <= kill ? '0 : ld_row[i-1];
      end
    end
  end
endmodule

// File: tb/tb_sa_wave_scheduler.sv
// tb_sa_wave_scheduler: cycle-level job model compared every cycle, plus literal timing pins
module tb_sa_wave_scheduler;
  import sa_wave_scheduler_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sa_wave_scheduler_if bus();
  sa_wave_scheduler dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int passed = 0, total = 0, cyc = 0;
  bit act = 0, perr = 0;
  int a = 0, mm = 0;
  int evf[10], evl[10];
  int errn, capn, maxpop;
  bit capok;
  int dq[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
  endtask

  task automatic clr_ev();
    for (int i = 0; i < 10; i++) begin evf[i] = -1; evl[i] = -1; end
    errn = 0; capn = 0; capok = 1; maxpop = 0; dq.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Job model: a job accepted at cycle a occupies cycles a+1 .. a+d, positions derived from rel = cyc-a
  always @(negedge clk) begin
    int rel, t, tl, d;
    bit st;
    logic [SA_N-1:0] ei, ec;
    logic [9:0] ev;
    rel = cyc - a;
    tl = RD_LAT + mm + 2 * SA_N - 2;
    d = SA_N + 2 + tl;
    t = rel - SA_N - 1;
    st = act && t >= 0 && t <= tl;
    for (int i = 0; i < SA_N; i++) begin
      ei[i] = st && t - RD_LAT - i >= 0 && t - RD_LAT - i < mm;
      ec[i] = st && t - RD_LAT - SA_N - i >= 0 && t - RD_LAT - SA_N - i < mm;
    end
    chk("busy", bus.busy, act);
    chk("done", bus.done, act && rel == d);
    chk("err", bus.err, perr);
    chk("wbuf_rd_en", bus.wbuf_rd_en, act && rel <= SA_N);
    chk("wbuf_rd_addr", bus.wbuf_rd_addr, (act && rel <= SA_N) ? rel - 1 : 0);
    chk("w_ld_en", bus.w_ld_en, act && rel > RD_LAT && rel <= SA_N + RD_LAT);
    chk("w_ld_row", bus.w_ld_row, (act && rel > RD_LAT && rel <= SA_N + RD_LAT) ? rel - 1 - RD_LAT : 0);
    chk("abuf_rd_en", bus.abuf_rd_en, st && t < mm);
    chk("abuf_rd_addr", bus.abuf_rd_addr, (st && t < mm) ? t : 0);
    chk("inj_en", bus.inj_en, ei);
    chk("cap_en", bus.cap_en, ec);
    chk("cap_idx", bus.cap_idx, ec[0] ? t - RD_LAT - SA_N : 0);
    ev = {bus.busy, bus.err, bus.done, bus.cap_en[9], bus.cap_en[0], bus.inj_en[9],
          bus.inj_en[0], bus.abuf_rd_en, bus.w_ld_en, bus.wbuf_rd_en};
    for (int i = 0; i < 10; i++)
      if (ev[i]) begin
        if (evf[i] < 0) evf[i] = cyc;
        evl[i] = cyc;
      end
    if (bus.err) errn++;
    if (bus.done) dq.push_back(cyc);
    if (bus.cap_en[0]) begin
      if (int'(bus.cap_idx) != capn) capok = 0;
      capn++;
    end
    if ($countones(bus.inj_en) > maxpop) maxpop = $countones(bus.inj_en);
    if (!rst_n) begin
      act = 0; perr = 0;
    end else begin
      perr = 0;
      if (act) begin
        if (rel == d || bus.abort) act = 0;
      end else if (bus.start) begin
        if (bus.cfg_m >= 1 && bus.cfg_m <= MAX_M) begin act = 1; a = cyc; mm = int'(bus.cfg_m); end
        else perr = 1;
      end
    end
    cyc++;
  end

  initial begin
    int s;
    bus.start = 0; bus.abort = 0; bus.cfg_m = '0;
    clr_ev();
    step(3);
    chk("rst_busy", bus.busy, 0);
    chk("rst_inj", bus.inj_en, 0);
    rst_n = 1;
    step(2);

    // 1: m=3 timeline
    clr_ev(); s = cyc;
    bus.start = 1; bus.cfg_m = 3; step(1); bus.start = 0; step(40);
    chk("t1_wb_first", evf[0] - s, 1);
    chk("t1_wb_last", evl[0] - s, 10);
    chk("t1_wld_first", evf[1] - s, 2);
    chk("t1_wld_last", evl[1] - s, 11);
    chk("t1_ab_first", evf[2] - s, 11);
    chk("t1_ab_last", evl[2] - s, 13);
    chk("t1_inj0_first", evf[3] - s, 12);
    chk("t1_inj9_first", evf[4] - s, 21);
    chk("t1_inj9_last", evl[4] - s, 23);
    chk("t1_cap0_first", evf[5] - s, 22);
    chk("t1_cap9_first", evf[6] - s, 31);
    chk("t1_cap9_last", evl[6] - s, 33);
    chk("t1_done", evf[7] - s, 34);
    chk("t1_done_width", evl[7] - evf[7], 0);

    // 2: rejected configs
    clr_ev(); s = cyc;
    bus.start = 1; bus.cfg_m = 0; step(1); bus.start = 0; step(2);
    bus.start = 1; bus.cfg_m = 33; step(1); bus.start = 0; step(3);
    chk("t2_errn", errn, 2);
    chk("t2_err_first", evf[8] - s, 1);
    chk("t2_no_read", evf[0], -1);
    chk("t2_no_busy", evf[9], -1);

    // 3: abort mid-stream, then start+abort together
    clr_ev(); s = cyc;
    bus.start = 1; bus.cfg_m = 3; step(1); bus.start = 0; step(14);
    bus.abort = 1; step(1); bus.abort = 0; step(3);
    chk("t3_busy_last", evl[9] - s, 15);
    chk("t3_no_done", evf[7], -1);
    clr_ev(); s = cyc;
    bus.start = 1; bus.abort = 1; bus.cfg_m = 2; step(1); bus.start = 0; bus.abort = 0; step(40);
    chk("t3_restart_wb", evf[0] - s, 1);
    chk("t3_restart_done", evf[7] - s, 33);

    // 4: start held high, back-to-back m=1 jobs
    clr_ev(); s = cyc;
    bus.start = 1; bus.cfg_m = 1; step(70); bus.start = 0; step(35);
    chk("t4_ndone", dq.size(), 3);
    chk("t4_done0", dq[0] - s, 32);
    chk("t4_done1", dq[1] - s, 65);
    chk("t4_done2", dq[2] - s, 98);

    // 5: reset mid-job
    clr_ev(); s = cyc;
    bus.start = 1; bus.cfg_m = 32; step(1); bus.start = 0; step(19);
    rst_n = 0; step(1); rst_n = 1; step(5);
    chk("t5_busy_last", evl[9] - s, 20);
    chk("t5_no_done", evf[7], -1);
    chk("t5_no_err", errn, 0);

    // 6: full-size job
    clr_ev(); s = cyc;
    bus.start = 1; bus.cfg_m = 32; step(1); bus.start = 0; step(70);
    chk("t6_done", evf[7] - s, 63);
    chk("t6_cap9_last", evl[6] - s, 62);
    chk("t6_capn", capn, 32);
    chk("t6_cap_seq", capok, 1);
    chk("t6_maxpop", maxpop, SA_N);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
